// File: rtl/csr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : csr_pkg
// Description : Shared CSR addresses, operation encoding, trap causes and
//               status bit positions for the machine-mode CSR unit.
// Revision    : 1.0 - initial release
// ============================================================================
package csr_pkg;

    typedef enum logic [1:0] {
        CSR_OP_NONE = 2'b00,
        CSR_OP_RW   = 2'b01,
        CSR_OP_RS   = 2'b10,
        CSR_OP_RC   = 2'b11
    } csr_op_e;

    localparam logic [11:0] C_ADDR_MSTATUS   = 12'h300;
    localparam logic [11:0] C_ADDR_MIE       = 12'h304;
    localparam logic [11:0] C_ADDR_MTVEC     = 12'h305;
    localparam logic [11:0] C_ADDR_MEPC      = 12'h341;
    localparam logic [11:0] C_ADDR_MCAUSE    = 12'h342;
    localparam logic [11:0] C_ADDR_MIP       = 12'h344;
    localparam logic [11:0] C_ADDR_MCYCLE    = 12'hB00;
    localparam logic [11:0] C_ADDR_MINSTRET  = 12'hB02;
    localparam logic [11:0] C_ADDR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] C_ADDR_MINSTRETH = 12'hB82;

    localparam int C_MSTATUS_MIE  = 3;
    localparam int C_MSTATUS_MPIE = 7;
    localparam int C_MIE_MTIE     = 7;
    localparam int C_MIE_MEIE     = 11;

    localparam logic [31:0] C_CAUSE_M_TIMER = 32'h8000_0007;
    localparam logic [31:0] C_CAUSE_M_EXT   = 32'h8000_000B;

    function automatic logic [31:0] csr_apply(
        input csr_op_e     op,
        input logic [31:0] old_val,
        input logic [31:0] wdata
    );
        logic [31:0] res;
        res = old_val;
        case (op)
            CSR_OP_RW: res = wdata;
            CSR_OP_RS: res = old_val | wdata;
            CSR_OP_RC: res = old_val & ~wdata;
            default:   res = old_val;
        endcase
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/csr_counter64.sv
`default_nettype none
// ============================================================================
// Module      : csr_counter64
// Description : 64-bit free-running counter with independent 32-bit half
//               writes; any half write drops that cycle's increment.
// Revision    : 1.0 - initial release
// ============================================================================
module csr_counter64 (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_inc_en,
    input  logic        i_wr_lo,
    input  logic        i_wr_hi,
    input  logic [31:0] i_wdata,
    output logic [63:0] o_count
);

    logic [63:0] count_q;
    logic [63:0] count_d;

    always_comb begin
        count_d = count_q;
        if (i_wr_lo || i_wr_hi) begin
            if (i_wr_lo) count_d[31:0]  = i_wdata;
            if (i_wr_hi) count_d[63:32] = i_wdata;
        end else if (i_inc_en) begin
            count_d = count_q + 64'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= 64'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_count = count_q;

endmodule
`default_nettype wire

// File: rtl/csr_unit.sv
`default_nettype none
// ============================================================================
// Module      : csr_unit
// Description : Machine-mode CSR file with read-modify-write access, 64-bit
//               counters, trap entry / mret and fetch redirect generation.
// Revision    : 1.0 - initial release
// ============================================================================
module csr_unit
    import csr_pkg::*;
#(
    parameter int          XLEN         = 32,
    parameter bit          HAS_COUNTERS = 1'b1,
    parameter logic [31:0] RESET_MTVEC  = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      csr_op,
    input  logic [11:0]     csr_addr,
    input  logic [XLEN-1:0] csr_wdata,
    output logic [XLEN-1:0] csr_rdata,
    output logic            csr_illegal,
    input  logic [XLEN-1:0] pc,
    input  logic            instr_retire,
    input  logic            exc_valid,
    input  logic [3:0]      exc_cause,
    input  logic            mret,
    input  logic            irq_timer,
    input  logic            irq_ext,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc
);

    logic        mstatus_mie_q,  mstatus_mie_d;
    logic        mstatus_mpie_q, mstatus_mpie_d;
    logic        mie_mtie_q,     mie_mtie_d;
    logic        mie_meie_q,     mie_meie_d;
    logic [31:0] mtvec_q,        mtvec_d;
    logic [31:0] mepc_q,         mepc_d;
    logic [31:0] mcause_q,       mcause_d;

    csr_op_e     w_op;
    logic        w_csr_req;
    logic        w_addr_hit;
    logic [31:0] w_old;
    logic [31:0] w_wval;
    logic        w_wen;
    logic [31:0] w_mstatus;
    logic [31:0] w_mie;
    logic [31:0] w_mip;
    logic [63:0] w_mcycle;
    logic [63:0] w_minstret;
    logic        w_int_ext;
    logic        w_int_tmr;
    logic        w_trap;
    logic        w_mret_take;
    logic [31:0] w_cause;
    logic [31:0] w_base;
    logic [31:0] w_trap_pc;
    logic        w_cyc_wr_lo, w_cyc_wr_hi;
    logic        w_ret_wr_lo, w_ret_wr_hi;
    logic        w_ret_inc;

    // Read view of the architectural CSRs
    always_comb begin
        w_mstatus                 = 32'd0;
        w_mstatus[12:11]          = 2'b11;
        w_mstatus[C_MSTATUS_MPIE] = mstatus_mpie_q;
        w_mstatus[C_MSTATUS_MIE]  = mstatus_mie_q;
        w_mie                     = 32'd0;
        w_mie[C_MIE_MTIE]         = mie_mtie_q;
        w_mie[C_MIE_MEIE]         = mie_meie_q;
        w_mip                     = 32'd0;
        w_mip[C_MIE_MTIE]         = irq_timer;
        w_mip[C_MIE_MEIE]         = irq_ext;
    end

    always_comb begin
        w_old      = 32'd0;
        w_addr_hit = 1'b1;
        case (csr_addr)
            C_ADDR_MSTATUS:   w_old = w_mstatus;
            C_ADDR_MIE:       w_old = w_mie;
            C_ADDR_MTVEC:     w_old = mtvec_q;
            C_ADDR_MEPC:      w_old = mepc_q;
            C_ADDR_MCAUSE:    w_old = mcause_q;
            C_ADDR_MIP:       w_old = w_mip;
            C_ADDR_MCYCLE:    w_old = w_mcycle[31:0];
            C_ADDR_MINSTRET:  w_old = w_minstret[31:0];
            C_ADDR_MCYCLEH:   w_old = w_mcycle[63:32];
            C_ADDR_MINSTRETH: w_old = w_minstret[63:32];
            default:          w_addr_hit = 1'b0;
        endcase
    end

    assign w_op      = csr_op_e'(csr_op);
    assign w_csr_req = (w_op != CSR_OP_NONE);
    assign w_wval    = csr_apply(w_op, w_old, csr_wdata);

    assign w_int_ext   = mstatus_mie_q & mie_meie_q & irq_ext;
    assign w_int_tmr   = mstatus_mie_q & mie_mtie_q & irq_timer;
    assign w_trap      = exc_valid | w_int_ext | w_int_tmr;
    assign w_mret_take = mret & ~w_trap;

    // RS/RC with a zero mask must not write: a write-back would stall counters
    assign w_wen = w_csr_req & w_addr_hit & ~w_trap & ~w_mret_take &
                   ((w_op == CSR_OP_RW) | (csr_wdata != 32'd0));

    assign w_cause   = exc_valid ? {28'd0, exc_cause}
                     : (w_int_ext ? C_CAUSE_M_EXT : C_CAUSE_M_TIMER);
    assign w_base    = {mtvec_q[31:2], 2'b00};
    assign w_trap_pc = (!exc_valid && (mtvec_q[1:0] == 2'b01))
                     ? (w_base + {26'd0, w_cause[3:0], 2'b00})
                     : w_base;

    always_comb begin
        mstatus_mie_d  = mstatus_mie_q;
        mstatus_mpie_d = mstatus_mpie_q;
        mie_mtie_d     = mie_mtie_q;
        mie_meie_d     = mie_meie_q;
        mtvec_d        = mtvec_q;
        mepc_d         = mepc_q;
        mcause_d       = mcause_q;
        if (w_trap) begin
            mepc_d         = pc & ~32'h3;
            mcause_d       = w_cause;
            mstatus_mpie_d = mstatus_mie_q;
            mstatus_mie_d  = 1'b0;
        end else if (w_mret_take) begin
            mstatus_mie_d  = mstatus_mpie_q;
            mstatus_mpie_d = 1'b1;
        end else if (w_wen) begin
            case (csr_addr)
                C_ADDR_MSTATUS: begin
                    mstatus_mie_d  = w_wval[C_MSTATUS_MIE];
                    mstatus_mpie_d = w_wval[C_MSTATUS_MPIE];
                end
                C_ADDR_MIE: begin
                    mie_mtie_d = w_wval[C_MIE_MTIE];
                    mie_meie_d = w_wval[C_MIE_MEIE];
                end
                C_ADDR_MTVEC:  mtvec_d  = w_wval;
                C_ADDR_MEPC:   mepc_d   = w_wval & ~32'h3;
                C_ADDR_MCAUSE: mcause_d = w_wval;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            mie_mtie_q     <= 1'b0;
            mie_meie_q     <= 1'b0;
            mtvec_q        <= RESET_MTVEC;
            mepc_q         <= 32'd0;
            mcause_q       <= 32'd0;
        end else begin
            mstatus_mie_q  <= mstatus_mie_d;
            mstatus_mpie_q <= mstatus_mpie_d;
            mie_mtie_q     <= mie_mtie_d;
            mie_meie_q     <= mie_meie_d;
            mtvec_q        <= mtvec_d;
            mepc_q         <= mepc_d;
            mcause_q       <= mcause_d;
        end
    end

    assign w_cyc_wr_lo = w_wen & (csr_addr == C_ADDR_MCYCLE);
    assign w_cyc_wr_hi = w_wen & (csr_addr == C_ADDR_MCYCLEH);
    assign w_ret_wr_lo = w_wen & (csr_addr == C_ADDR_MINSTRET);
    assign w_ret_wr_hi = w_wen & (csr_addr == C_ADDR_MINSTRETH);
    assign w_ret_inc   = instr_retire & ~w_trap;

    generate
        if (HAS_COUNTERS) begin : g_counters
            csr_counter64 u_mcycle (
                .clk      (clk),
                .rst      (rst),
                .i_inc_en (1'b1),
                .i_wr_lo  (w_cyc_wr_lo),
                .i_wr_hi  (w_cyc_wr_hi),
                .i_wdata  (w_wval),
                .o_count  (w_mcycle)
            );
            csr_counter64 u_minstret (
                .clk      (clk),
                .rst      (rst),
                .i_inc_en (w_ret_inc),
                .i_wr_lo  (w_ret_wr_lo),
                .i_wr_hi  (w_ret_wr_hi),
                .i_wdata  (w_wval),
                .o_count  (w_minstret)
            );
        end else begin : g_no_counters
            assign w_mcycle   = 64'd0;
            assign w_minstret = 64'd0;
        end
    endgenerate

    assign csr_rdata      = (w_csr_req && w_addr_hit) ? w_old : 32'd0;
    assign csr_illegal    = w_csr_req & ~w_addr_hit;
    assign redirect_valid = ~rst & (w_trap | w_mret_take);
    assign redirect_pc    = w_trap ? w_trap_pc : mepc_q;

endmodule
`default_nettype wire

// File: tb/tb_csr_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_csr_unit
// Description : Directed self-checking bench for csr_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_csr_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  csr_op;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        csr_illegal;
    logic [31:0] pc;
    logic        instr_retire;
    logic        exc_valid;
    logic [3:0]  exc_cause;
    logic        mret;
    logic        irq_timer;
    logic        irq_ext;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    logic [31:0] nc_rdata;
    logic        nc_illegal;
    logic        nc_redirect_valid;
    logic [31:0] nc_redirect_pc;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    csr_unit dut (
        .clk(clk), .rst(rst), .csr_op(csr_op), .csr_addr(csr_addr),
        .csr_wdata(csr_wdata), .csr_rdata(csr_rdata), .csr_illegal(csr_illegal),
        .pc(pc), .instr_retire(instr_retire), .exc_valid(exc_valid),
        .exc_cause(exc_cause), .mret(mret), .irq_timer(irq_timer),
        .irq_ext(irq_ext), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    csr_unit #(.HAS_COUNTERS(1'b0)) dut_nc (
        .clk(clk), .rst(rst), .csr_op(csr_op), .csr_addr(csr_addr),
        .csr_wdata(csr_wdata), .csr_rdata(nc_rdata), .csr_illegal(nc_illegal),
        .pc(pc), .instr_retire(instr_retire), .exc_valid(exc_valid),
        .exc_cause(exc_cause), .mret(mret), .irq_timer(irq_timer),
        .irq_ext(irq_ext), .redirect_valid(nc_redirect_valid), .redirect_pc(nc_redirect_pc)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [1:0] op, input logic [11:0] a, input logic [31:0] d);
        csr_op    = op;
        csr_addr  = a;
        csr_wdata = d;
    endtask

    task automatic csr_write(input logic [11:0] a, input logic [31:0] d);
        set_op(2'b01, a, d);
        step();
        set_op(2'b00, 12'h0, 32'h0);
    endtask

    task automatic csr_read(input logic [11:0] a, output logic [31:0] v);
        set_op(2'b10, a, 32'h0);
        #2;
        v = csr_rdata;
        step();
        set_op(2'b00, 12'h0, 32'h0);
    endtask

    task automatic test_reset();
        logic [31:0] v;
        rst = 1'b1; set_op(2'b00, 12'h0, 32'h0);
        pc = 32'h100; instr_retire = 1'b0; exc_valid = 1'b1; exc_cause = 4'd5;
        mret = 1'b0; irq_timer = 1'b0; irq_ext = 1'b0;
        #2;
        checks++;
        if (redirect_valid !== 1'b0) begin
            errors++; $display("FAIL reset_redirect: got %b expected 0", redirect_valid);
        end
        step(); step();
        rst = 1'b0; exc_valid = 1'b0;
        #2;
        checks++;
        if (csr_rdata !== 32'h0 || redirect_valid !== 1'b0 || csr_illegal !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: rdata=%h rv=%b ill=%b expected 0/0/0",
                     csr_rdata, redirect_valid, csr_illegal);
        end
        csr_read(12'h342, v);
        checks++;
        if (v !== 32'h0) begin errors++; $display("FAIL reset_mcause: got %h expected 0", v); end
        csr_read(12'h300, v);
        checks++;
        if (v !== 32'h0000_1800) begin errors++; $display("FAIL reset_mstatus: got %h expected 00001800", v); end
    endtask

    task automatic test_mtvec_rw();
        logic [31:0] v;
        set_op(2'b01, 12'h305, 32'h0000_1001);
        #2;
        checks++;
        if (csr_rdata !== 32'h0) begin errors++; $display("FAIL mtvec_old: got %h expected 0", csr_rdata); end
        step();
        set_op(2'b00, 12'h0, 32'h0);
        csr_read(12'h305, v);
        checks++;
        if (v !== 32'h0000_1001) begin errors++; $display("FAIL mtvec_new: got %h expected 00001001", v); end
    endtask

    task automatic test_interrupt();
        logic [31:0] v;
        csr_write(12'h304, 32'h880);
        set_op(2'b10, 12'h300, 32'h8);
        step();
        set_op(2'b00, 12'h0, 32'h0);
        csr_read(12'h304, v);
        checks++;
        if (v !== 32'h880) begin errors++; $display("FAIL mie_value: got %h expected 00000880", v); end
        pc = 32'h300; irq_ext = 1'b1;
        #2;
        checks++;
        if (redirect_valid !== 1'b1 || redirect_pc !== 32'h0000_102C) begin
            errors++;
            $display("FAIL irq_redirect: got %b/%h expected 1/0000102c", redirect_valid, redirect_pc);
        end
        step();
        irq_ext = 1'b0;
        csr_read(12'h342, v);
        checks++;
        if (v !== 32'h8000_000B) begin errors++; $display("FAIL irq_mcause: got %h expected 8000000b", v); end
        csr_read(12'h300, v);
        checks++;
        if (v !== 32'h0000_1880) begin errors++; $display("FAIL irq_mstatus: got %h expected 00001880", v); end
        csr_read(12'h341, v);
        checks++;
        if (v !== 32'h300) begin errors++; $display("FAIL irq_mepc: got %h expected 00000300", v); end
        irq_timer = 1'b1;
        set_op(2'b10, 12'h344, 32'h0);
        #2;
        checks++;
        if (csr_rdata !== 32'h80 || redirect_valid !== 1'b0) begin
            errors++;
            $display("FAIL mip_masked: got %h/%b expected 00000080/0", csr_rdata, redirect_valid);
        end
        step();
        set_op(2'b00, 12'h0, 32'h0);
        irq_timer = 1'b0;
    endtask

    task automatic test_exception();
        logic [31:0] v;
        pc = 32'h200; exc_valid = 1'b1; exc_cause = 4'd2;
        set_op(2'b01, 12'h341, 32'hDEAD_BEEC);
        #2;
        checks++;
        if (redirect_valid !== 1'b1 || redirect_pc !== 32'h0000_1000) begin
            errors++;
            $display("FAIL exc_redirect: got %b/%h expected 1/00001000", redirect_valid, redirect_pc);
        end
        step();
        exc_valid = 1'b0;
        set_op(2'b00, 12'h0, 32'h0);
        csr_read(12'h341, v);
        checks++;
        if (v !== 32'h200) begin errors++; $display("FAIL exc_mepc: got %h expected 00000200", v); end
        csr_read(12'h342, v);
        checks++;
        if (v !== 32'h2) begin errors++; $display("FAIL exc_mcause: got %h expected 00000002", v); end
        csr_read(12'h300, v);
        checks++;
        if (v !== 32'h0000_1800) begin errors++; $display("FAIL exc_mstatus: got %h expected 00001800", v); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] v;
        set_op(2'b11, 12'h304, 32'h80);
        #2;
        checks++;
        if (csr_rdata !== 32'h880) begin errors++; $display("FAIL b2b_rc_old: got %h expected 00000880", csr_rdata); end
        step();
        set_op(2'b10, 12'h304, 32'h80);
        #2;
        checks++;
        if (csr_rdata !== 32'h800) begin errors++; $display("FAIL b2b_rs_old: got %h expected 00000800", csr_rdata); end
        step();
        set_op(2'b00, 12'h0, 32'h0);
        csr_read(12'h304, v);
        checks++;
        if (v !== 32'h880) begin errors++; $display("FAIL b2b_final: got %h expected 00000880", v); end
    endtask

    task automatic test_mret();
        logic [31:0] v;
        csr_write(12'h341, 32'h207);
        csr_write(12'h300, 32'h80);
        csr_read(12'h341, v);
        checks++;
        if (v !== 32'h204) begin errors++; $display("FAIL mepc_align: got %h expected 00000204", v); end
        mret = 1'b1;
        #2;
        checks++;
        if (redirect_valid !== 1'b1 || redirect_pc !== 32'h204) begin
            errors++;
            $display("FAIL mret_redirect: got %b/%h expected 1/00000204", redirect_valid, redirect_pc);
        end
        step();
        mret = 1'b0;
        csr_read(12'h300, v);
        checks++;
        if (v !== 32'h0000_1888) begin errors++; $display("FAIL mret_mstatus: got %h expected 00001888", v); end
    endtask

    task automatic test_illegal();
        logic [31:0] v;
        set_op(2'b11, 12'h7C0, 32'hFFFF_FFFF);
        #2;
        checks++;
        if (csr_illegal !== 1'b1 || csr_rdata !== 32'h0) begin
            errors++;
            $display("FAIL illegal_flag: got %b/%h expected 1/00000000", csr_illegal, csr_rdata);
        end
        step();
        set_op(2'b00, 12'h0, 32'h0);
        csr_read(12'h305, v);
        checks++;
        if (v !== 32'h0000_1001) begin errors++; $display("FAIL illegal_mtvec: got %h expected 00001001", v); end
        csr_read(12'h300, v);
        checks++;
        if (v !== 32'h0000_1888) begin errors++; $display("FAIL illegal_mstatus: got %h expected 00001888", v); end
    endtask

    task automatic test_counters();
        logic [31:0] v;
        csr_write(12'hB00, 32'hFFFF_FFFF);
        csr_write(12'hB80, 32'h0);
        csr_read(12'hB00, v);
        checks++;
        if (v !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mcycle_written: got %h expected ffffffff", v); end
        csr_read(12'hB00, v);
        checks++;
        if (v !== 32'h0) begin errors++; $display("FAIL mcycle_wrap: got %h expected 00000000", v); end
        set_op(2'b10, 12'hB80, 32'h0);
        #2;
        checks++;
        if (csr_rdata !== 32'h1) begin errors++; $display("FAIL mcycleh_carry: got %h expected 00000001", csr_rdata); end
        checks++;
        if (nc_rdata !== 32'h0 || nc_illegal !== 1'b0) begin
            errors++;
            $display("FAIL nocnt_mcycleh: got %h/%b expected 00000000/0", nc_rdata, nc_illegal);
        end
        step();
        set_op(2'b00, 12'h0, 32'h0);
        instr_retire = 1'b1;
        csr_write(12'hB02, 32'h5);
        csr_read(12'hB02, v);
        checks++;
        if (v !== 32'h5) begin errors++; $display("FAIL minstret_write: got %h expected 00000005", v); end
        pc = 32'h40; exc_valid = 1'b1; exc_cause = 4'd3;
        set_op(2'b10, 12'hB02, 32'h0);
        #2;
        checks++;
        if (csr_rdata !== 32'h6) begin errors++; $display("FAIL minstret_inc: got %h expected 00000006", csr_rdata); end
        step();
        exc_valid = 1'b0; instr_retire = 1'b0;
        set_op(2'b00, 12'h0, 32'h0);
        csr_read(12'hB02, v);
        checks++;
        if (v !== 32'h6) begin errors++; $display("FAIL minstret_trap: got %h expected 00000006", v); end
    endtask

    initial begin
        test_reset();
        test_mtvec_rw();
        test_interrupt();
        test_exception();
        test_back_to_back();
        test_mret();
        test_illegal();
        test_counters();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/csr_unit.md
# csr_unit

Machine-mode control/status register unit for the single-cycle RV32 core, replacing the fixed six-entry CSR file. Supports CSRRW/CSRRS/CSRRC read-modify-write semantics, 64-bit cycle and retired-instruction counters, and exception/interrupt trap entry and `mret` return. Trap entry and return produce a PC redirect to the fetch stage. Sits beside the register file, addressed by the decode stage.

## Interface
- `XLEN`, 32: datapath width. Only 32 is supported.
- `HAS_COUNTERS`, 1: when 0, `mcycle[h]` and `minstret[h]` read 0 and ignore writes.
- `RESET_MTVEC`, 32'h0000_0000: reset value of `mtvec`.
---
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high
- `csr_op`  in  2  00 none, 01 RW, 10 RS, 11 RC
- `csr_addr`  in  12  inst[31:20]
- `csr_wdata`  in  32  rs1 value or zero-extended uimm
- `csr_rdata`  out  32  old CSR value, combinational
- `csr_illegal`  out  1  op≠none on an unimplemented address
- `pc`  in  32  PC of the current instruction
- `instr_retire`  in  1  current instruction retires this cycle
- `exc_valid`  in  1  synchronous exception
- `exc_cause`  in  4  exception code
- `mret`  in  1  current instruction is `mret`
- `irq_timer`, `irq_ext`  in  1 each  level interrupt lines
- `redirect_valid`  out  1  take `redirect_pc` next cycle
- `redirect_pc`  out  32  trap vector or `mepc`

## Operation
- Implemented CSRs: `mstatus` 0x300 (MIE bit 3, MPIE bit 7, MPP[12:11] reads 2'b11, all other bits 0), `mie` 0x304 (MTIE bit 7, MEIE bit 11 writable), `mtvec` 0x305, `mepc` 0x341 (bits [1:0] forced to 0), `mcause` 0x342, `mip` 0x344 (read-only MTIP/MEIP = live lines), `mcycle` 0xB00, `minstret` 0xB02, `mcycleh` 0xB80, `minstreth` 0xB82.
- Write value: RW = wdata; RS = old | wdata; RC = old & ~wdata. RS/RC with wdata = 0 still read, no side effect.
- Unimplemented address with op≠none: `csr_illegal`=1, `csr_rdata`=0, no state change.
- Interrupt pending: `int_take` = MIE & ((MTIE & irq_timer) | (MEIE & irq_ext)). External beats timer; cause = 0x8000_000B / 0x8000_0007.
- Priority: exception > interrupt > mret > CSR write. Trap or mret suppresses the CSR write in the same cycle.
- Trap entry: `mepc`←pc, `mcause`←cause, MPIE←MIE, MIE←0, redirect to base = {mtvec[31:2],2'b00}; if mtvec[1:0]=01 and interrupt, redirect to base + 4·code.
- mret: MIE←MPIE, MPIE←1, redirect to `mepc`.
- Counters: `mcycle` +1 every cycle; `minstret` +1 when `instr_retire` and no trap; both 64-bit, wrap to 0. A CSR write to either half replaces that half this cycle, and the increment is dropped that cycle.

## Timing
- Reset: all CSRs 0 except `mtvec`=RESET_MTVEC; `csr_rdata`=0 with op none; `redirect_valid`=0.
- Reads are combinational from current state. Writes, trap updates and counter updates occur at posedge.
- `redirect_valid`/`redirect_pc` are combinational in the trap/mret cycle. Fetch loads them at the same edge.
- `rst` during a trap cycle: reset wins and no CSR is updated.
- An interrupt line is sampled only in the cycle it is evaluated. There is no latching; `mip` mirrors the lines.

## Structure
- `csr_pkg`: CSR address localparams, `csr_op_e` enum, cause codes, mstatus bit indices.
- Sub-module `csr_counter64`: 64-bit counter with increment enable and lo/hi write ports. Instantiated twice.

## Test plan
- Reset, then `csrrw` 0x305 with 0x0000_1001 → rdata=0; next read=0x0000_1001.
- `mie`=0x880, `csrrs` `mstatus` with 0x8, assert `irq_ext` → redirect_valid=1, redirect_pc=0x1000+44=0x102C, mcause=0x8000_000B, MIE=0, MPIE=1.
- `exc_valid` with cause 2 at pc 0x200 while `csr_op`=RW to `mepc` → mepc=0x200, write suppressed, redirect to 0x1000.
- `mret` with mepc=0x204 → redirect_pc=0x204, MIE=1, MPIE=1.
- `mcycle` written to 0xFFFF_FFFF, `mcycleh`=0 → next cycle `mcycleh`=1, `mcycle`=0.
- `csrrc` on 0x7C0 → csr_illegal=1, rdata=0, no state changes.
